// File: rtl/move_ctrl_if.sv
// Port bundle between the move controller and its environment (inputs/timer,
// collision checker, board update). The slave modport is the controller's view.
interface move_ctrl_if #(
  parameter int COL_W      = 4,
  parameter int ROW_W      = 5,
  parameter int BRICK_LEN  = 3,
  parameter int DIR_LEN    = 2,
  parameter int BOARD_SIZE = 200
);
  localparam int POS_LEN = ROW_W + COL_W;

  logic                  spawn;
  logic [BRICK_LEN-1:0]  spawn_type;
  logic                  tick;
  logic                  cmd_valid;
  logic [2:0]            cmd;
  logic                  cmd_ready;
  logic [BOARD_SIZE-1:0] board;
  logic [POS_LEN-1:0]    chk_pos;
  logic [BRICK_LEN-1:0]  chk_type;
  logic [DIR_LEN-1:0]    chk_dir;
  logic                  chk_collided;
  logic [POS_LEN-1:0]    cur_pos;
  logic [BRICK_LEN-1:0]  cur_type;
  logic [DIR_LEN-1:0]    cur_dir;
  logic                  piece_active;
  logic                  lock_pulse;
  logic                  game_over;

  modport master (
    output spawn, spawn_type, tick, cmd_valid, cmd, board, chk_collided,
    input  cmd_ready, chk_pos, chk_type, chk_dir, cur_pos, cur_type, cur_dir,
           piece_active, lock_pulse, game_over
  );

  modport slave (
    input  spawn, spawn_type, tick, cmd_valid, cmd, board, chk_collided,
    output cmd_ready, chk_pos, chk_type, chk_dir, cur_pos, cur_type, cur_dir,
           piece_active, lock_pulse, game_over
  );
endinterface

// File: rtl/move_ctrl.sv
// Falling-piece move controller: arbitrates gravity vs. player commands and
// runs one candidate per cycle through the external collision checker.
module move_ctrl #(
  parameter int COL_W     = 4,
  parameter int ROW_W     = 5,
  parameter int BRICK_LEN = 3,
  parameter int DIR_LEN   = 2,
  parameter int POS_LEN   = ROW_W + COL_W,
  parameter logic [POS_LEN-1:0] SPAWN_POS = POS_LEN'(3)
) (
  input logic clk,
  input logic rst,
  move_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_SPAWN_CHK, S_CHECK, S_HDROP, S_LOCK
  } state_t;

  localparam logic [POS_LEN-1:0] ROW_ONE = POS_LEN'(1) << COL_W;

  state_t               state, state_nxt;
  logic [POS_LEN-1:0]   cur_pos, chk_pos;
  logic [BRICK_LEN-1:0] cur_type, chk_type;
  logic [DIR_LEN-1:0]   cur_dir, chk_dir;
  logic                 piece_active, game_over, tick_pend;
  logic                 is_down, force_hit;
  logic                 cmd_ready, lock_pulse;

  logic [ROW_W-1:0] cur_row;
  logic [COL_W-1:0] cur_col;
  logic             in_idle, tick_any, spawn_go, tick_go, cmd_go, hit;

  assign cur_row  = cur_pos[POS_LEN-1:COL_W];
  assign cur_col  = cur_pos[COL_W-1:0];
  assign in_idle  = (state == S_IDLE);
  // A tick in the current cycle outranks a command even before it is latched.
  assign tick_any = bus.tick | tick_pend;
  assign spawn_go = in_idle && bus.spawn && !piece_active && !game_over;
  assign tick_go  = in_idle && piece_active && tick_any;
  assign cmd_go   = bus.cmd_valid && cmd_ready;
  assign hit      = bus.chk_collided | force_hit;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (spawn_go)     state_nxt = S_SPAWN_CHK;
        else if (tick_go) state_nxt = S_CHECK;
        else if (cmd_go) begin
          if (bus.cmd <= 3'd3)      state_nxt = S_CHECK;
          else if (bus.cmd == 3'd4) state_nxt = S_HDROP;
        end
      end
      S_SPAWN_CHK: state_nxt = S_IDLE;
      S_CHECK:     state_nxt = (hit && is_down) ? S_LOCK : S_IDLE;
      S_HDROP:     if (hit) state_nxt = S_LOCK;
      S_LOCK:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = in_idle && piece_active && !tick_any && !game_over;
    lock_pulse = (state == S_LOCK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_pos      <= '0;
      cur_type     <= '0;
      cur_dir      <= '0;
      chk_pos      <= '0;
      chk_type     <= '0;
      chk_dir      <= '0;
      piece_active <= 1'b0;
      game_over    <= 1'b0;
      tick_pend    <= 1'b0;
      is_down      <= 1'b0;
      force_hit    <= 1'b0;
    end else begin
      if (bus.tick && piece_active) tick_pend <= 1'b1;
      case (state)
        S_IDLE: begin
          if (spawn_go) begin
            chk_pos   <= SPAWN_POS;
            chk_type  <= bus.spawn_type;
            chk_dir   <= '0;
            is_down   <= 1'b0;
            force_hit <= 1'b0;
          end else if (tick_go) begin
            tick_pend <= 1'b0;
            chk_pos   <= cur_pos + ROW_ONE;
            chk_type  <= cur_type;
            chk_dir   <= cur_dir;
            is_down   <= 1'b1;
            force_hit <= 1'b0;
          end else if (cmd_go && bus.cmd <= 3'd4) begin
            chk_pos   <= cur_pos;
            chk_type  <= cur_type;
            chk_dir   <= cur_dir;
            is_down   <= 1'b0;
            force_hit <= 1'b0;
            case (bus.cmd)
              3'd0: begin
                chk_pos   <= {cur_row, cur_col - 1'b1};
                force_hit <= (cur_col == '0);
              end
              3'd1: chk_pos <= {cur_row, cur_col + 1'b1};
              3'd2: chk_dir <= cur_dir + 1'b1;
              default: begin
                chk_pos <= cur_pos + ROW_ONE;
                is_down <= 1'b1;
              end
            endcase
          end
        end
        S_SPAWN_CHK: begin
          if (!hit) begin
            cur_pos      <= chk_pos;
            cur_type     <= chk_type;
            cur_dir      <= chk_dir;
            piece_active <= 1'b1;
          end else begin
            game_over <= 1'b1;
          end
        end
        S_CHECK: begin
          if (!hit) begin
            cur_pos  <= chk_pos;
            cur_type <= chk_type;
            cur_dir  <= chk_dir;
          end
        end
        S_HDROP: begin
          if (!hit) begin
            cur_pos <= chk_pos;
            chk_pos <= chk_pos + ROW_ONE;
          end
        end
        S_LOCK: begin
          piece_active <= 1'b0;
          tick_pend    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready    = cmd_ready;
  assign bus.lock_pulse   = lock_pulse;
  assign bus.chk_pos      = chk_pos;
  assign bus.chk_type     = chk_type;
  assign bus.chk_dir      = chk_dir;
  assign bus.cur_pos      = cur_pos;
  assign bus.cur_type     = cur_type;
  assign bus.cur_dir      = cur_dir;
  assign bus.piece_active = piece_active;
  assign bus.game_over    = game_over;
endmodule

// File: tb/tb_move_ctrl.sv
// Directed bench for move_ctrl; the collision checker is modelled as a row
// floor (block_row) plus a force override.
module tb_move_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  bit   force_coll = 1'b0;
  int   block_row = 32;

  always #5 clk = ~clk;

  move_ctrl_if bus ();
  move_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  assign bus.chk_collided = force_coll || (int'(bus.chk_pos[8:4]) >= block_row);

  task automatic test_reset();
    rst = 1'b1;
    bus.spawn = 1'b0; bus.spawn_type = '0; bus.tick = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd = '0; bus.board = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.cur_pos !== 9'd0) begin errors++; $display("FAIL reset_cur_pos got %0d want 0", bus.cur_pos); end
    checks++; if (bus.chk_pos !== 9'd0) begin errors++; $display("FAIL reset_chk_pos got %0d want 0", bus.chk_pos); end
    checks++; if (bus.piece_active !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", bus.piece_active); end
    checks++; if (bus.lock_pulse !== 1'b0) begin errors++; $display("FAIL reset_lock got %b want 0", bus.lock_pulse); end
    checks++; if (bus.game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over got %b want 0", bus.game_over); end
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got %b want 0", bus.cmd_ready); end
  endtask

  task automatic test_spawn();
    bus.spawn = 1'b1; bus.spawn_type = 3'd2;
    @(negedge clk);
    bus.spawn = 1'b0;
    checks++; if (bus.chk_pos !== 9'd3 || bus.chk_type !== 3'd2) begin errors++; $display("FAIL spawn_chk got pos %0d type %0d want 3 2", bus.chk_pos, bus.chk_type); end
    checks++; if (bus.piece_active !== 1'b0) begin errors++; $display("FAIL spawn_early_active got %b want 0", bus.piece_active); end
    @(negedge clk);
    checks++; if (bus.piece_active !== 1'b1) begin errors++; $display("FAIL spawn_active got %b want 1", bus.piece_active); end
    checks++; if (bus.cur_pos !== 9'd3) begin errors++; $display("FAIL spawn_pos got %0d want 3", bus.cur_pos); end
    checks++; if (bus.cur_type !== 3'd2 || bus.cur_dir !== 2'd0) begin errors++; $display("FAIL spawn_type_dir got %0d %0d want 2 0", bus.cur_type, bus.cur_dir); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL spawn_ready got %b want 1", bus.cmd_ready); end
  endtask

  task automatic test_left();
    for (int i = 0; i < 4; i++) begin
      int exp_col;
      exp_col = (i < 3) ? 2 - i : 0;
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL left_ready_pre[%0d] got %b want 1", i, bus.cmd_ready); end
      bus.cmd_valid = 1'b1; bus.cmd = 3'd0;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL left_ready_busy[%0d] got %b want 0", i, bus.cmd_ready); end
      @(negedge clk);
      checks++; if (int'(bus.cur_pos) !== exp_col) begin errors++; $display("FAIL left_pos[%0d] got %0d want %0d", i, bus.cur_pos, exp_col); end
    end
    checks++; if (bus.lock_pulse !== 1'b0 || bus.piece_active !== 1'b1) begin errors++; $display("FAIL left_wall got lock %b active %b want 0 1", bus.lock_pulse, bus.piece_active); end
  endtask

  task automatic test_rotate();
    for (int i = 0; i < 4; i++) begin
      bus.cmd_valid = 1'b1; bus.cmd = 3'd2;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      checks++; if (int'(bus.cur_dir) !== (i + 1) % 4) begin errors++; $display("FAIL rotate_dir[%0d] got %0d want %0d", i, bus.cur_dir, (i + 1) % 4); end
    end
    force_coll = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd = 3'd2;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checks++; if (bus.lock_pulse !== 1'b0) begin errors++; $display("FAIL rotate_block_lock0 got %b want 0", bus.lock_pulse); end
    @(negedge clk);
    force_coll = 1'b0;
    checks++; if (bus.cur_dir !== 2'd0) begin errors++; $display("FAIL rotate_block_dir got %0d want 0", bus.cur_dir); end
    checks++; if (bus.lock_pulse !== 1'b0 || bus.piece_active !== 1'b1) begin errors++; $display("FAIL rotate_block_state got lock %b active %b want 0 1", bus.lock_pulse, bus.piece_active); end
  endtask

  task automatic test_hard_drop();
    int found;
    block_row = 18;
    bus.cmd_valid = 1'b1; bus.cmd = 3'd4;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    found = -1;
    for (int k = 0; k < 40 && found < 0; k++) begin
      if (bus.lock_pulse === 1'b1) found = k;
      else @(negedge clk);
    end
    checks++; if (found !== 18) begin errors++; $display("FAIL hdrop_lock_cycle got %0d want 18", found); end
    checks++; if (bus.cur_pos !== 9'd272) begin errors++; $display("FAIL hdrop_lock_pos got %0d want 272", bus.cur_pos); end
    @(negedge clk);
    checks++; if (bus.lock_pulse !== 1'b0) begin errors++; $display("FAIL hdrop_lock_width got %b want 0", bus.lock_pulse); end
    checks++; if (bus.piece_active !== 1'b0) begin errors++; $display("FAIL hdrop_inactive got %b want 0", bus.piece_active); end
  endtask

  task automatic test_tick_cmd();
    bus.spawn = 1'b1; bus.spawn_type = 3'd1;
    @(negedge clk);
    bus.spawn = 1'b0;
    @(negedge clk);
    bus.tick = 1'b1; bus.cmd_valid = 1'b1; bus.cmd = 3'd1;
    #1;
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL tick_ready_comb got %b want 0", bus.cmd_ready); end
    @(negedge clk);
    bus.tick = 1'b0;
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL tick_ready_busy got %b want 0", bus.cmd_ready); end
    @(negedge clk);
    checks++; if (bus.cur_pos !== 9'd19) begin errors++; $display("FAIL tick_down_first got %0d want 19", bus.cur_pos); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL tick_ready_back got %b want 1", bus.cmd_ready); end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.cur_pos !== 9'd20) begin errors++; $display("FAIL tick_right_after got %0d want 20", bus.cur_pos); end
  endtask

  task automatic test_back_to_back();
    int found;
    bus.cmd_valid = 1'b1; bus.cmd = 3'd4;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    found = -1;
    for (int k = 0; k < 40 && found < 0; k++) begin
      if (bus.lock_pulse === 1'b1) found = k;
      else begin
        bus.tick = (k == 2 || k == 5 || k == 8);
        @(negedge clk);
      end
    end
    bus.tick = 1'b0;
    checks++; if (found !== 17) begin errors++; $display("FAIL b2b_lock_cycle got %0d want 17", found); end
    checks++; if (bus.cur_pos !== 9'd276) begin errors++; $display("FAIL b2b_lock_pos got %0d want 276", bus.cur_pos); end
    repeat (5) @(negedge clk);
    checks++; if (bus.cur_pos !== 9'd276 || bus.piece_active !== 1'b0) begin errors++; $display("FAIL b2b_no_extra got pos %0d active %b want 276 0", bus.cur_pos, bus.piece_active); end
    // A fresh piece must not inherit a stale gravity tick.
    bus.spawn = 1'b1; bus.spawn_type = 3'd3;
    @(negedge clk);
    bus.spawn = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (bus.cur_pos !== 9'd3 || bus.piece_active !== 1'b1) begin errors++; $display("FAIL b2b_stale_tick got pos %0d active %b want 3 1", bus.cur_pos, bus.piece_active); end
    block_row = 1;
    bus.cmd_valid = 1'b1; bus.cmd = 3'd3;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.lock_pulse !== 1'b1 || bus.cur_pos !== 9'd3) begin errors++; $display("FAIL soft_down_lock got lock %b pos %0d want 1 3", bus.lock_pulse, bus.cur_pos); end
    @(negedge clk);
    checks++; if (bus.piece_active !== 1'b0) begin errors++; $display("FAIL soft_down_inactive got %b want 0", bus.piece_active); end
  endtask

  task automatic test_game_over();
    force_coll = 1'b1;
    bus.spawn = 1'b1; bus.spawn_type = 3'd4;
    @(negedge clk);
    bus.spawn = 1'b0;
    @(negedge clk);
    checks++; if (bus.game_over !== 1'b1 || bus.piece_active !== 1'b0) begin errors++; $display("FAIL go_set got go %b active %b want 1 0", bus.game_over, bus.piece_active); end
    checks++; if (bus.cur_type !== 3'd3) begin errors++; $display("FAIL go_cur_kept got %0d want 3", bus.cur_type); end
    force_coll = 1'b0;
    bus.spawn = 1'b1; bus.spawn_type = 3'd5;
    @(negedge clk);
    bus.spawn = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.game_over !== 1'b1 || bus.piece_active !== 1'b0) begin errors++; $display("FAIL go_sticky got go %b active %b want 1 0", bus.game_over, bus.piece_active); end
    checks++; if (bus.chk_type !== 3'd4) begin errors++; $display("FAIL go_spawn_ignored got %0d want 4", bus.chk_type); end
  endtask

  task automatic test_reset_mid_drop();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    block_row = 18;
    bus.spawn = 1'b1; bus.spawn_type = 3'd6;
    @(negedge clk);
    bus.spawn = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd = 3'd4;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (bus.cur_pos !== 9'd67) begin errors++; $display("FAIL rst_mid_progress got %0d want 67", bus.cur_pos); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.cur_pos !== 9'd0 || bus.cur_type !== 3'd0 || bus.cur_dir !== 2'd0) begin errors++; $display("FAIL rst_mid_cur got %0d %0d %0d want 0 0 0", bus.cur_pos, bus.cur_type, bus.cur_dir); end
    checks++; if (bus.chk_pos !== 9'd0 || bus.chk_type !== 3'd0) begin errors++; $display("FAIL rst_mid_chk got %0d %0d want 0 0", bus.chk_pos, bus.chk_type); end
    checks++; if (bus.piece_active !== 1'b0 || bus.game_over !== 1'b0) begin errors++; $display("FAIL rst_mid_flags got %b %b want 0 0", bus.piece_active, bus.game_over); end
    repeat (3) @(negedge clk);
    checks++; if (bus.lock_pulse !== 1'b0 || bus.cur_pos !== 9'd0 || bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_abandon got lock %b pos %0d ready %b want 0 0 0", bus.lock_pulse, bus.cur_pos, bus.cmd_ready); end
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_left();
    test_rotate();
    test_hard_drop();
    test_tick_cmd();
    test_back_to_back();
    test_game_over();
    test_reset_mid_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
